// File: rtl/bcd_countdown.sv
// -----------------------------------------------------------------------------
// bcd_countdown
//   Two-digit BCD countdown counter. A preset (00-99) is loaded, started,
//   optionally paused/resumed, and a one-cycle done pulse marks the cycle in
//   which the count first shows 00. A prescaler stretches each decrement to
//   TICK_DIV run cycles.
//
//   Optional feature: define BCD_COUNTDOWN_AUTO_RELOAD_EN to make the counter
//   reload its last preset one tick after reaching 00 (periodic decade timer).
//
// Parameters:
//   TICK_DIV  run cycles per decrement, 1..65535
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   load      in   load load_val (highest priority)
//   load_val  in   [7:4] tens, [3:0] ones, BCD preset
//   start     in   start from IDLE / resume from PAUSE
//   pause     in   freeze counting while running
//   q         out  current count, BCD
//   busy      out  high while running or paused
//   done      out  one-cycle pulse when q first shows 00
//   err       out  one-cycle pulse after a rejected (non-BCD) load
// -----------------------------------------------------------------------------
module bcd_countdown #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] q,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    state_t      r_state;
    logic [7:0]  r_q;
    logic [15:0] r_presc;
    logic        r_done;
    logic        r_err;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    logic [7:0]  r_reload;
`endif

    logic        w_load_ok;
    logic        w_tick;
    logic        w_at_zero;
    logic [7:0]  w_q_dec;

    // One BCD step down; the caller never applies it to 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] != 4'd0)
            return {v[7:4], v[3:0] - 4'd1};
        else
            return {v[7:4] - 4'd1, 4'd9};
    endfunction

    assign w_load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
    assign w_tick    = (r_presc == TICK_LAST);
    assign w_at_zero = (r_q == 8'h00);
    assign w_q_dec   = bcd_dec(r_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_q      <= 8'h00;
            r_presc  <= 16'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
            r_reload <= 8'h00;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (load) begin
                // A rejected load still claims the edge: nothing else moves.
                if (w_load_ok) begin
                    r_q     <= load_val;
                    r_presc <= 16'd0;
                    r_state <= S_IDLE;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                    r_reload <= load_val;
`endif
                end else begin
                    r_err <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // pause outranks start even where it has no effect itself
                        if (!pause && start && !w_at_zero) begin
                            r_state <= S_RUN;
                            r_presc <= 16'd0;
                        end
                    end
                    S_RUN: begin
                        if (pause) begin
                            r_state <= S_PAUSE;
                        end else if (w_tick) begin
                            r_presc <= 16'd0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                            if (w_at_zero) begin
                                // tick after reaching 00: restart the period
                                if (r_reload != 8'h00)
                                    r_q <= r_reload;
                                else
                                    r_state <= S_IDLE;
                            end else begin
                                r_q <= w_q_dec;
                                if (w_q_dec == 8'h00)
                                    r_done <= 1'b1;
                            end
`else
                            r_q <= w_q_dec;
                            if (w_q_dec == 8'h00) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end
`endif
                        end else begin
                            r_presc <= r_presc + 16'd1;
                        end
                    end
                    S_PAUSE: begin
                        // resume keeps the prescaler where it was frozen
                        if (!pause && start)
                            r_state <= S_RUN;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign q    = r_q;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd_countdown.sv
// -----------------------------------------------------------------------------
// tb_bcd_countdown
//   Directed bench for bcd_countdown: one instance with TICK_DIV=1 and one with
//   TICK_DIV=4 share clock, reset and control inputs; each section checks the
//   instance it targets. Build with BCD_COUNTDOWN_AUTO_RELOAD_EN defined to
//   exercise the auto-reload variant.
// -----------------------------------------------------------------------------
module tb_bcd_countdown;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;

    logic [7:0] q1, q4;
    logic       busy1, busy4, done1, done4, err1, err4;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    localparam logic AR = 1'b1;
`else
    localparam logic AR = 1'b0;
`endif

    bcd_countdown #(.TICK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .pause(pause),
        .q(q1), .busy(busy1), .done(done1), .err(err1)
    );

    bcd_countdown #(.TICK_DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .pause(pause),
        .q(q4), .busy(busy4), .done(done4), .err(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [7:0] seq12 [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                               8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

    initial begin
        reset = 1'b1; load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0;
        step();
        chk("rst_q",    q1, 8'h00);
        chk("rst_busy", 8'(busy1), 8'd0);
        chk("rst_done", 8'(done1), 8'd0);
        chk("rst_err",  8'(err1),  8'd0);
        reset = 1'b0;
        step();

        // ---- preset 12, TICK_DIV=1, full countdown with ones borrow
        do_load(8'h12);
        chk("ld12_q", q1, 8'h12);
        chk("ld12_busy", 8'(busy1), 8'd0);
        do_start();
        chk("st12_q", q1, 8'h12);
        chk("st12_busy", 8'(busy1), 8'd1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("cnt12_q[%0d]", i), q1, seq12[i]);
            chk($sformatf("cnt12_done[%0d]", i), 8'(done1), 8'(seq12[i] == 8'h00));
            chk($sformatf("cnt12_busy[%0d]", i), 8'(busy1), 8'((seq12[i] != 8'h00) || AR));
        end
        step();
        chk("post12_done", 8'(done1), 8'd0);
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        chk("post12_q", q1, 8'h12);
`else
        chk("post12_q", q1, 8'h00);
        chk("post12_busy", 8'(busy1), 8'd0);
`endif

        // ---- TICK_DIV=4: decrement spacing, pause/resume keeps prescaler
        do_load(8'h02);
        chk("d4_ld_q", q4, 8'h02);
        do_start();
        chk("d4_st_busy", 8'(busy4), 8'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("d4_wait_q[%0d]", i), q4, 8'h02);
        end
        step();
        chk("d4_dec1_q", q4, 8'h01);
        step();
        step();
        chk("d4_pre_pause_q", q4, 8'h01);
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("d4_pause_busy", 8'(busy4), 8'd1);
        for (int i = 0; i < 10; i++) step();
        chk("d4_hold_q", q4, 8'h01);
        chk("d4_hold_busy", 8'(busy4), 8'd1);
        do_start();
        chk("d4_resume_q", q4, 8'h01);
        step();
        chk("d4_r1_q", q4, 8'h01);
        step();
        chk("d4_r2_q", q4, 8'h00);
        chk("d4_r2_done", 8'(done4), 8'd1);
        chk("d4_r2_busy", 8'(busy4), 8'(AR));
        step();
        chk("d4_r3_done", 8'(done4), 8'd0);

        // ---- rejected load, load of 00 then start
        do_load(8'h35);
        chk("ld35_q", q1, 8'h35);
        chk("ld35_err", 8'(err1), 8'd0);
        do_load(8'h1A);
        chk("ld1A_err", 8'(err1), 8'd1);
        chk("ld1A_q", q1, 8'h35);
        step();
        chk("ld1A_err_clr", 8'(err1), 8'd0);
        chk("ld1A_q2", q1, 8'h35);
        do_load(8'hA3);
        chk("ldA3_err", 8'(err1), 8'd1);
        chk("ldA3_q", q1, 8'h35);
        do_load(8'h00);
        do_start();
        chk("ld00_busy", 8'(busy1), 8'd0);
        chk("ld00_q", q1, 8'h00);

        // ---- load on the edge that would reach 00; load+pause+start
        do_load(8'h02);
        do_start();
        step();
        chk("lt_q01", q1, 8'h01);
        do_load(8'h45);
        chk("lt_q", q1, 8'h45);
        chk("lt_done", 8'(done1), 8'd0);
        chk("lt_busy", 8'(busy1), 8'd0);
        load = 1'b1; pause = 1'b1; start = 1'b1; load_val = 8'h27;
        step();
        load = 1'b0; pause = 1'b0; start = 1'b0;
        chk("lps_q", q1, 8'h27);
        chk("lps_busy", 8'(busy1), 8'd0);

        // ---- asynchronous reset mid-count
        do_load(8'h08);
        do_start();
        step();
        chk("ar_q07", q1, 8'h07);
        #2 reset = 1'b1;
        #1;
        chk("ar_q", q1, 8'h00);
        chk("ar_busy", 8'(busy1), 8'd0);
        chk("ar_done", 8'(done1), 8'd0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("ar_post_q", q1, 8'h00);
        chk("ar_post_busy", 8'(busy1), 8'd0);

        // ---- preset 03: stop at 00, or reload with the macro
        do_load(8'h03);
        do_start();
        step(); chk("p3_q02", q1, 8'h02);
        step(); chk("p3_q01", q1, 8'h01);
        step();
        chk("p3_q00", q1, 8'h00);
        chk("p3_done", 8'(done1), 8'd1);
        step();
        chk("p3_done_clr", 8'(done1), 8'd0);
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        chk("p3_reload_q", q1, 8'h03);
        chk("p3_reload_busy", 8'(busy1), 8'd1);
        step(); chk("p3_r_q02", q1, 8'h02);
        step(); chk("p3_r_q01", q1, 8'h01);
        step();
        chk("p3_r_q00", q1, 8'h00);
        chk("p3_r_done", 8'(done1), 8'd1);
`else
        chk("p3_stop_q", q1, 8'h00);
        chk("p3_stop_busy", 8'(busy1), 8'd0);
        step();
        chk("p3_stop_q2", q1, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_countdown.md
# bcd_countdown

Two-digit BCD countdown counter, the down-counting complement of the team's mod-10 up counter. Software or a control FSM loads a preset (00–99), starts it, may pause and resume it, and receives a one-cycle `done` pulse when the count reaches 00. An optional auto-reload mode turns it into a periodic decade timer. It sits beside the up counter in the timing and control path and is cascade-friendly through its BCD outputs.

## Interface
- `TICK_DIV`, default 1: number of RUN-state cycles per decrement; legal range 1–65535.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `load`  input  1  load `load_val` into the count; highest priority.
- `load_val`  input  8  BCD preset: [7:4] tens, [3:0] ones.
- `start`  input  1  start from IDLE or resume from PAUSE.
- `pause`  input  1  freeze counting while in RUN.
- `q`  output  8  current count in BCD: [7:4] tens, [3:0] ones.
- `busy`  output  1  high in RUN or PAUSE.
- `done`  output  1  one-cycle pulse, asserted in the same cycle that `q` first shows 00.
- `err`  output  1  one-cycle pulse after a rejected (non-BCD) load.

## Operation
- States:
  - IDLE: holding, not counting.
  - RUN: prescaler advancing; decrements on each tick.
  - PAUSE: count and prescaler frozen.
- Reset values: `q`=8'h00, state=IDLE, prescaler=0, reload register=8'h00, `busy`=0, `done`=0, `err`=0.
- Input priority on any edge: `load` > `pause` > `start`.
- Load:
  - Accepted in any state when both nibbles are ≤9. Then `q`←`load_val`, reload register←`load_val`, prescaler←0, state←IDLE.
  - If either nibble is >9, the load is ignored: `q` and state are unchanged and `err`=1 for one cycle.
- Start:
  - IDLE with `q`≠00: go to RUN, prescaler←0.
  - IDLE with `q`=00: ignored.
  - PAUSE: go to RUN with the prescaler kept.
  - RUN: no effect.
- Pause: RUN→PAUSE. Ignored in IDLE and PAUSE.
- Tick: in RUN, a tick occurs when prescaler = `TICK_DIV`-1. On a tick the prescaler goes to 0; otherwise it increments.
- Decrement on a tick:
  - If ones>0: ones−1.
  - Otherwise: ones←9 and tens−1.
  - Tens never underflows, because the counter never decrements from 00.
- Reaching 00: the tick that makes `q` go 01→00 also sets state←IDLE (non-reload build) and sets `done` high for that one cycle.
- `busy` is decoded combinationally from the state register.
- Asserting `reset` at any point, including mid-count or in PAUSE, returns every register to its reset value immediately.

## Timing
- Load asserted for edge N: new `q` is visible after edge N. `err` is high during the cycle following edge N.
- Start sampled at edge N (from IDLE): `busy`=1 after edge N. First decrement at edge N+`TICK_DIV`; further decrements every `TICK_DIV` cycles.
- With `TICK_DIV`=1 and a preset of 03: `q` = 02, 01, 00 after edges N+1, N+2, N+3. `done`=1 and `busy`=0 after edge N+3. `done`=0 after edge N+4.
- Pause sampled at edge P: no decrement at edge P, even if a tick was due. Resume picks up the remaining prescaler count.
- Load and tick on the same edge: load wins and the tick is discarded.
- Load with `done`: a load sampled on the edge that would reach 00 takes priority, so `done` does not pulse.
- `done` and `err` never stay high for more than one cycle.

## Configuration
- Macro `BCD_COUNTDOWN_AUTO_RELOAD_EN`.
- Defined:
  - On reaching 00 the state stays RUN and `done` pulses as usual.
  - On the next tick `q`←reload register. This gives a period of (preset+1)×`TICK_DIV` cycles.
  - If the reload register is 00, the counter goes to IDLE instead.
  - `pause` and `load` behave as normal.
- Undefined:
  - Reload logic is absent and reaching 00 always returns to IDLE.
  - The reload register may be optimised away; `q` loads are unaffected.

## Test plan
- Reset, then load 8'h12 and start with `TICK_DIV`=1 → `q` steps 11, 10, 09 (ones borrow at 10→09) … 00. `done` is high exactly one cycle, together with `q`=00. `busy` drops in the same cycle.
- `TICK_DIV`=4, preset 02, start → decrements exactly 4 cycles apart. Pause 2 cycles after the first decrement, hold 10 cycles, resume → next decrement 2 cycles after resume.
- Load 8'h1A → `err` pulses one cycle and `q` keeps its old value. Load 8'h00 then start → stays IDLE and `busy`=0.
- Load asserted on the same edge as a due tick at `q`=01 → `q` takes the load value and there is no `done` pulse. `load`, `pause` and `start` asserted together → load wins.
- Assert `reset` mid-count at `q`=07 in RUN → `q`=00, `busy`=0, `done`=0 immediately without waiting for a clock edge. Counting stays stopped after `reset` is released.
- With `BCD_COUNTDOWN_AUTO_RELOAD_EN`, preset 03, `TICK_DIV`=1 → `q` runs 03, 02, 01, 00, 03, 02 … with `done` every 4 cycles. Without the macro it stops at 00.
